// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner, in-order imem fetch into a credit-limited FIFO.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [31:0]              imem_rdata_i,
    output logic                     if_valid_o,
    output logic [31:0]              if_inst_o,
    output logic [31:0]              if_pc4_o,
    input  logic                     if_ready_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [31:0]              perf_stall_o,
    output logic [31:0]              perf_flush_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, resp_pc_q;
    logic [CW-1:0] count_q, out_q, out_d, drop_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc4_mem  [DEPTH];
    logic          grant, resp, push, pop;
    logic [31:0]   redirect_pc;
    logic [CW:0]   credit;
    logic          unused_rpc;

    assign unused_rpc  = ^redirect_pc_i[1:0];
    assign redirect_pc = {redirect_pc_i[31:2], 2'b00};

    // Credits cover both buffered and in-flight words, so a response always fits.
    assign credit     = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req_o = (state_q == RUN) && !redirect_i
                        && (out_q < CW'(MAX_OUT))
                        && (credit < (CW + 1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;

    assign grant = imem_req_o && imem_gnt_i;
    assign resp  = imem_rvalid_i && (out_q != '0);
    assign push  = resp && (drop_q == '0) && !redirect_i;
    assign pop   = if_valid_o && if_ready_i;
    assign out_d = out_q + CW'(grant) - CW'(resp);

    assign if_valid_o  = (count_q != '0);
    assign if_inst_o   = if_valid_o ? inst_mem[rd_ptr_q] : '0;
    assign if_pc4_o    = if_valid_o ? pc4_mem[rd_ptr_q] : '0;
    assign occupancy_o = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (!start_i) state_d = HALT;
            HALT:    if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc;
                resp_pc_q  <= redirect_pc;
                drop_q     <= out_d;
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                if (grant) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                    wr_ptr_q  <= wr_ptr_q + AW'(1);
                end
                if (resp && (drop_q != '0)) drop_q <= drop_q - CW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata_i;
            pc4_mem[wr_ptr_q]  <= resp_pc_q + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, flush_q;
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flush_q} + 33'(credit);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (if_valid_o && !if_ready_i && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (redirect_i)
                flush_q <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    assign perf_stall_o = stall_q;
    assign perf_flush_o = flush_q;
`else
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized and directed checks of if_fetch_queue
// against a queue-based reference model with a latency memory model.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc4_o;
    logic        if_ready_i = 1'b0;
    logic [2:0]  occupancy_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_flush_o;

    if_fetch_queue #(
        .DEPTH(DEPTH),
        .MAX_OUT(MAX_OUT),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o),
        .if_inst_o(if_inst_o),
        .if_pc4_o(if_pc4_o),
        .if_ready_i(if_ready_i),
        .occupancy_o(occupancy_o),
        .perf_stall_o(perf_stall_o),
        .perf_flush_o(perf_flush_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] mq[$];
    int          epoch = 0;
    int          mout = 0;
    logic [31:0] mpc = RESET_PC;
    longint      stall_m = 0;
    longint      flush_m = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic model_reset();
        mq.delete();
        epoch++;
        mout = 0;
        mpc = RESET_PC;
        stall_m = 0;
        flush_m = 0;
    endtask

    task automatic idle_inputs();
        start_i = 1'b0;
        redirect_i = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        if_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle_inputs();
        memq.delete();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic drive_cycle(input logic rdy, input logic st,
                               input logic rd, input logic [31:0] rpc);
        @(posedge clk_i);
        #1;
        if_ready_i = rdy;
        start_i = st;
        redirect_i = rd;
        redirect_pc_i = rpc;
        imem_gnt_i = (int'($urandom_range(99)) < gnt_pct);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = memq[0].data;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i = $urandom;
        end
        @(negedge clk_i);
    endtask

    // Advance the reference model by the cycle whose inputs are now applied.
    task automatic commit();
        mreq_t e;
        int pre;
        pre = mq.size() + mout;
        if (mq.size() != 0 && !if_ready_i) stall_m++;
        if (mq.size() != 0 && if_ready_i) void'(mq.pop_front());
        if (imem_rvalid_i && memq.size() > 0) begin
            e = memq.pop_front();
            if (mout > 0) begin
                mout--;
                if (e.epoch == epoch && !redirect_i) mq.push_back(e.pc);
            end
        end
        if (imem_req_o && imem_gnt_i) begin
            memq.push_back('{data: imem_addr_o >> 2, pc: mpc, epoch: epoch,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
            mout++;
            mpc = mpc + 32'd4;
        end
        if (redirect_i) begin
            flush_m += pre;
            mq.delete();
            epoch++;
            mpc = redirect_pc_i & 32'hFFFF_FFFC;
        end
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b0;
        #2;
        n_tests++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_req got %0b want 0", imem_req_o);
        end
        n_tests++;
        if (imem_addr_o !== RESET_PC) begin
            n_fail++; $display("FAIL reset_addr got %h want %h", imem_addr_o, RESET_PC);
        end
        n_tests++;
        if (if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %0b want 0", if_valid_o);
        end
        n_tests++;
        if (if_inst_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst got %h want 0", if_inst_o);
        end
        n_tests++;
        if (if_pc4_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc4 got %h want 0", if_pc4_o);
        end
        n_tests++;
        if (occupancy_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy_o);
        end
        n_tests++;
        if (perf_stall_o !== 32'h0 || perf_flush_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_perf got %h/%h want 0/0", perf_stall_o, perf_flush_o);
        end
        do_reset();
    endtask

    task automatic test_stream();
        int npop = 0;
        int pcyc[4];
        logic [31:0] pi[4];
        logic [31:0] pp[4];
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (if_valid_o && npop < 4) begin
                pi[npop] = if_inst_o; pp[npop] = if_pc4_o; pcyc[npop] = c;
                npop++;
            end
            commit();
        end
        n_tests++;
        if (npop != 4) begin
            n_fail++; $display("FAIL stream_pops got %0d want 4", npop);
        end
        for (int i = 0; i < npop; i++) begin
            n_tests++;
            if (pi[i] !== 32'(i) || pp[i] !== 32'(4 * (i + 1))) begin
                n_fail++;
                $display("FAIL stream_word%0d got %h/%h want %h/%h",
                         i, pi[i], pp[i], i, 4 * (i + 1));
            end
        end
        if (npop == 4) begin
            n_tests++;
            if (pcyc[0] != 3 || pcyc[3] - pcyc[0] != 3) begin
                n_fail++;
                $display("FAIL stream_timing got first %0d span %0d want 3/3",
                         pcyc[0], pcyc[3] - pcyc[0]);
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] head;
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        head = if_inst_o;
        commit();
        for (int c = 0; c < 9; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if (if_inst_o !== head) begin
                n_fail++; $display("FAIL full_head got %h want %h", if_inst_o, head);
            end
            commit();
        end
        n_tests++;
        if (occupancy_o !== 3'd4) begin
            n_fail++; $display("FAIL full_occ got %0d want 4", occupancy_o);
        end
        n_tests++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL full_req got %0b want 0", imem_req_o);
        end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if (if_valid_o !== 1'b1 || if_inst_o !== head + 32'(k)) begin
                n_fail++;
                $display("FAIL full_drain%0d got %0b/%h want 1/%h",
                         k, if_valid_o, if_inst_o, head + 32'(k));
            end
            commit();
        end
    endtask

    task automatic test_redirect_drop();
        int c = 0;
        bit found = 0;
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        while (mout < 2 && c < 20) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0); commit(); c++;
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        n_tests++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL redir_req got %0b want 0", imem_req_o);
        end
        commit();
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (occupancy_o !== 3'd0) begin
            n_fail++; $display("FAIL redir_occ got %0d want 0", occupancy_o);
        end
        commit();
        for (int i = 0; i < 30 && !found; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (if_valid_o) begin
                found = 1;
                n_tests++;
                if (if_inst_o !== 32'h40 || if_pc4_o !== 32'h104) begin
                    n_fail++;
                    $display("FAIL redir_first got %h/%h want 00000040/00000104",
                             if_inst_o, if_pc4_o);
                end
            end
            commit();
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL redir_timeout got no valid want valid within 30 cycles");
        end
    endtask

    task automatic test_redirect_pop();
        bit found = 0;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (6) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0); commit();
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        n_tests++;
        if (if_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rpop_valid got %0b want 1", if_valid_o);
        end
        commit();
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (occupancy_o !== 3'd0 || if_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rpop_empty got %0d/%0b want 0/0", occupancy_o, if_valid_o);
        end
        commit();
        for (int i = 0; i < 20 && !found; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (if_valid_o) begin
                found = 1;
                n_tests++;
                if (if_inst_o !== 32'h80 || if_pc4_o !== 32'h204) begin
                    n_fail++;
                    $display("FAIL rpop_first got %h/%h want 00000080/00000204",
                             if_inst_o, if_pc4_o);
                end
            end
            commit();
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL rpop_timeout got no valid want valid within 20 cycles");
        end
    endtask

    task automatic test_halt();
        int c = 0;
        bit found = 0;
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        while (mout < 2 && c < 20) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 32'h0); commit(); c++;
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
            n_tests++;
            if (imem_req_o !== 1'b0) begin
                n_fail++; $display("FAIL halt_req%0d got %0b want 0", i, imem_req_o);
            end
            commit();
        end
        n_tests++;
        if (occupancy_o !== 3'd2 || if_inst_o !== 32'h0 || if_pc4_o !== 32'h4) begin
            n_fail++;
            $display("FAIL halt_fifo got %0d/%h/%h want 2/00000000/00000004",
                     occupancy_o, if_inst_o, if_pc4_o);
        end
        for (int i = 0; i < 10 && !found; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_req_o) begin
                found = 1;
                n_tests++;
                if (imem_addr_o !== 32'h8) begin
                    n_fail++; $display("FAIL halt_resume got %h want 00000008", imem_addr_o);
                end
            end
            commit();
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL halt_timeout got no req want req within 10 cycles");
        end
    endtask

    task automatic test_mid_reset();
        int c = 0;
        bit got_req = 0;
        bit got_val = 0;
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        while (mout < 2 && c < 20) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0); commit(); c++;
        end
        #2;
        rst_i = 1'b0;
        #1;
        n_tests++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
            n_fail++;
            $display("FAIL mrst_ctl got %0b/%0b/%0d want 0/0/0",
                     imem_req_o, if_valid_o, occupancy_o);
        end
        n_tests++;
        if (if_inst_o !== 32'h0 || if_pc4_o !== 32'h0 || imem_addr_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL mrst_data got %h/%h/%h want 0/0/%h",
                     if_inst_o, if_pc4_o, imem_addr_o, RESET_PC);
        end
        idle_inputs();
        model_reset();
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            n_tests++;
            if (occupancy_o !== 3'd0 || if_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL mrst_late%0d got %0d/%0b want 0/0",
                         i, occupancy_o, if_valid_o);
            end
            commit();
        end
        for (int i = 0; i < 15 && !got_val; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_req_o && !got_req) begin
                got_req = 1;
                n_tests++;
                if (imem_addr_o !== RESET_PC) begin
                    n_fail++;
                    $display("FAIL mrst_addr got %h want %h", imem_addr_o, RESET_PC);
                end
            end
            if (if_valid_o) begin
                got_val = 1;
                n_tests++;
                if (if_inst_o !== 32'h0 || if_pc4_o !== 32'h4) begin
                    n_fail++;
                    $display("FAIL mrst_first got %h/%h want 00000000/00000004",
                             if_inst_o, if_pc4_o);
                end
            end
            commit();
        end
        if (!got_val) begin
            n_tests++; n_fail++;
            $display("FAIL mrst_timeout got no valid want valid within 15 cycles");
        end
    endtask

    task automatic test_random();
        logic st = 1'b1;
        logic rdy, rd;
        do_reset();
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(3) != 0);
            rd = ($urandom_range(19) == 0);
            if ($urandom_range(31) == 0) st = !st;
            drive_cycle(rdy, st, rd, $urandom);
            n_tests++;
            if (int'(occupancy_o) != mq.size() || if_valid_o !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_occ c%0d got %0d/%0b want %0d/%0b",
                         i, occupancy_o, if_valid_o, mq.size(), mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_tests++;
                if (if_inst_o !== (mq[0] >> 2) || if_pc4_o !== mq[0] + 32'd4) begin
                    n_fail++;
                    $display("FAIL rnd_head c%0d got %h/%h want %h/%h",
                             i, if_inst_o, if_pc4_o, mq[0] >> 2, mq[0] + 32'd4);
                end
            end
            if (imem_req_o) begin
                n_tests++;
                if (imem_addr_o !== mpc || rd
                    || (mq.size() + mout) >= DEPTH || mout >= MAX_OUT) begin
                    n_fail++;
                    $display("FAIL rnd_req c%0d got addr %h redir %0b credit %0d/%0d want addr %h",
                             i, imem_addr_o, rd, mq.size(), mout, mpc);
                end
            end
            commit();
        end
        n_tests++;
`ifdef FETCH_PERF_EN
        if (perf_stall_o !== 32'(stall_m) || perf_flush_o !== 32'(flush_m)) begin
            n_fail++;
            $display("FAIL rnd_perf got %0d/%0d want %0d/%0d",
                     perf_stall_o, perf_flush_o, stall_m, flush_m);
        end
`else
        if (perf_stall_o !== 32'h0 || perf_flush_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rnd_perf got %0d/%0d want 0/0", perf_stall_o, perf_flush_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_pop();
        test_halt();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
